// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared types and constants for the data-memory port-B arbiter:
//   arbiter state encoding, default memory geometry and the tag that
//   travels with each accepted beat to its response cycle.
package dmem_arb_pkg;

  localparam int DMEM_DEPTH = 70000;
  localparam int DMEM_AW    = 17;
  localparam int DMEM_DW    = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic owner;     // 0 = requester 0, 1 = requester 1
    logic is_write;
    logic err;       // address was out of range
  } rsp_tag_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick
//   Two-way combinational picker producing a one-hot grant.
//   Ports:
//     i_v0, i_v1  request valids
//     i_last      last-served requester (1 = requester 1)
//     i_rr_en     1 = round-robin on contention, 0 = requester 0 first
//     o_gnt       one-hot grant, bit k = requester k
module dmem_arb_pick (
  input  logic       i_v0,
  input  logic       i_v1,
  input  logic       i_last,
  input  logic       i_rr_en,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    if (i_v0 && i_v1) begin
      // Under round-robin the requester not served last wins.
      if (i_rr_en && !i_last) o_gnt = 2'b10;
      else                    o_gnt = 2'b01;
    end else if (i_v0) begin
      o_gnt = 2'b01;
    end else if (i_v1) begin
      o_gnt = 2'b10;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares RAM port B between a read-only scanner (requester 0) and a
//   read/write agent (requester 1). Supports locked bursts capped at
//   MAX_BURST beats, range-checks word addresses against DEPTH and
//   returns each response one cycle after acceptance.
//   Optional build macro: DMEM_ARB_RR_EN selects round-robin arbitration
//   in IDLE; without it requester 0 has fixed priority.
//   Ports:
//     clk, rst_n                  clock, synchronous active-low reset
//     r0_valid/ready/addr/lock    requester 0 request
//     r0_rvalid/err/rdata         requester 0 response
//     r1_valid/ready/we/addr/wdata/lock  requester 1 request
//     r1_rvalid/err/rdata         requester 1 response
//     mem_addr/wd/we, mem_q       RAM port B (mem_q has 1-cycle latency)
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH     = DMEM_DEPTH,
  parameter int AW        = DMEM_AW,
  parameter int DW        = DMEM_DW,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          r0_valid,
  output logic          r0_ready,
  input  logic [AW-1:0] r0_addr,
  input  logic          r0_lock,
  output logic          r0_rvalid,
  output logic          r0_err,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_valid,
  output logic          r1_ready,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  input  logic          r1_lock,
  output logic          r1_rvalid,
  output logic          r1_err,
  output logic [DW-1:0] r1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_q
);

  localparam int            CW       = $clog2(MAX_BURST + 1);
  localparam logic [AW:0]   LP_DEPTH = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] LP_MAX   = CW'(MAX_BURST);

  arb_state_e    r_state, w_state_nxt;
  logic [CW-1:0] r_burst_cnt, w_burst_nxt;
  logic          w_last;
  logic          w_last_nxt;
  logic [1:0]    w_pick;
  logic          w_acc0, w_acc1, w_any, w_lock, w_inrange;
  logic [AW-1:0] w_addr;
  logic          r_rsp_vld_p1;
  rsp_tag_t      r_tag_p1;
  logic          w_rsp_on;

`ifdef DMEM_ARB_RR_EN
  localparam logic LP_RR = 1'b1;
  logic r_last;
  assign w_last = r_last;

  always_ff @(posedge clk) begin
    if (!rst_n) r_last <= 1'b1;
    else        r_last <= w_last_nxt;
  end
`else
  localparam logic LP_RR = 1'b0;
  assign w_last = 1'b1;
`endif

  dmem_arb_pick u_pick (
    .i_v0    (r0_valid),
    .i_v1    (r1_valid),
    .i_last  (w_last),
    .i_rr_en (LP_RR),
    .o_gnt   (w_pick)
  );

  // Ready: picker result in IDLE, owner only while a burst is locked.
  always_comb begin
    r0_ready = 1'b0;
    r1_ready = 1'b0;
    if (rst_n) begin
      case (r_state)
        ST_IDLE: begin
          r0_ready = w_pick[0];
          r1_ready = w_pick[1];
        end
        ST_OWN0: r0_ready = r0_valid;
        ST_OWN1: r1_ready = r1_valid;
        default: ;
      endcase
    end
  end

  assign w_acc0    = r0_valid & r0_ready;
  assign w_acc1    = r1_valid & r1_ready;
  assign w_any     = w_acc0 | w_acc1;
  assign w_addr    = w_acc1 ? r1_addr : (w_acc0 ? r0_addr : '0);
  assign w_lock    = w_acc1 ? r1_lock : (w_acc0 & r0_lock);
  assign w_inrange = ({1'b0, w_addr} < LP_DEPTH);

  // Out-of-range beats are still accepted but never reach the RAM.
  assign mem_addr = (w_any & w_inrange) ? w_addr   : '0;
  assign mem_wd   = (w_any & w_inrange) ? r1_wdata : '0;
  assign mem_we   = w_acc1 & w_inrange & r1_we;

  always_comb begin
    w_state_nxt = r_state;
    w_burst_nxt = r_burst_cnt;
    w_last_nxt  = w_last;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_last_nxt = w_acc1;
          if (w_lock && (MAX_BURST > 1)) begin
            w_state_nxt = w_acc1 ? ST_OWN1 : ST_OWN0;
            w_burst_nxt = CW'(1);
          end
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (!w_any) begin
          // Owner dropped valid: the lock is released immediately.
          w_state_nxt = ST_IDLE;
          w_burst_nxt = '0;
        end else if (!w_lock || (r_burst_cnt + CW'(1) >= LP_MAX)) begin
          w_state_nxt = ST_IDLE;
          w_burst_nxt = '0;
          if (w_lock) w_last_nxt = w_acc1;
        end else begin
          w_burst_nxt = r_burst_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_burst_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_burst_nxt;
    end
  end

  // ---- stage p1: response one cycle after accept ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_vld_p1 <= 1'b0;
      r_tag_p1     <= '0;
    end else begin
      r_rsp_vld_p1 <= w_any;
      r_tag_p1     <= '{owner: w_acc1, is_write: w_acc1 & r1_we, err: w_any & ~w_inrange};
    end
  end

  // Responses are suppressed while reset is held so a pending beat never shows.
  assign w_rsp_on  = r_rsp_vld_p1 & rst_n;
  assign r0_rvalid = w_rsp_on & ~r_tag_p1.owner;
  assign r1_rvalid = w_rsp_on &  r_tag_p1.owner;
  assign r0_err    = r0_rvalid & r_tag_p1.err;
  assign r1_err    = r1_rvalid & r_tag_p1.err;
  assign r0_rdata  = (r0_rvalid & ~r_tag_p1.err) ? mem_q : '0;
  assign r1_rdata  = (r1_rvalid & ~r_tag_p1.err & ~r_tag_p1.is_write) ? mem_q : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
//   Scoreboard bench for dmem_port_arbiter with a behavioural RAM on port B.
//   Build with DMEM_ARB_RR_EN to exercise the round-robin variant.
module tb_dmem_port_arbiter;

  localparam int AW        = 17;
  localparam int DW        = 32;
  localparam int DEPTH     = 70000;
  localparam int MAX_BURST = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          r0_valid, r0_ready, r0_lock, r0_rvalid, r0_err;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_rdata;
  logic          r1_valid, r1_ready, r1_we, r1_lock, r1_rvalid, r1_err;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata, r1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd, mem_q;
  logic          mem_we;

  always #5 clk = ~clk;

  dmem_port_arbiter #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr), .r0_lock(r0_lock),
    .r0_rvalid(r0_rvalid), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_lock(r1_lock),
    .r1_rvalid(r1_rvalid), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_q(mem_q)
  );

  logic [DW-1:0] ram    [0:DEPTH-1];
  logic [DW-1:0] shadow [0:DEPTH-1];

  always @(posedge clk) begin
    if (mem_we && int'(mem_addr) < DEPTH) ram[mem_addr] <= mem_wd;
    mem_q <= (int'(mem_addr) < DEPTH) ? ram[mem_addr] : 32'hBAD0BAD0;
  end

  typedef struct {
    bit            owner;
    logic [DW-1:0] rdata;
    bit            err;
    int            due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Response monitor, sampled mid-cycle after the registered outputs settle.
  exp_t m;
  always @(negedge clk) begin
    #2;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      m = sb.pop_front();
      check_eq("rsp_rvalid0", r0_rvalid, !m.owner);
      check_eq("rsp_rvalid1", r1_rvalid, m.owner);
      check_eq("rsp_rdata", m.owner ? r1_rdata : r0_rdata, m.rdata);
      check_eq("rsp_err", m.owner ? r1_err : r0_err, m.err);
    end else begin
      check_eq("quiet_rvalid", {r0_rvalid, r1_rvalid}, 0);
      check_eq("quiet_err", {r0_err, r1_err}, 0);
      check_eq("quiet_rdata", r0_rdata | r1_rdata, 0);
    end
  end

  // g: expected winner this cycle (0, 1) or -1 for no grant.
  task automatic drive(input bit v0, input int a0, input bit l0,
                       input bit v1, input bit we, input int a1,
                       input logic [DW-1:0] wd, input bit l1, input int g);
    exp_t e;
    int   a;
    bit   in_rng;
    @(negedge clk);
    r0_valid = v0; r0_addr = a0[AW-1:0]; r0_lock = l0;
    r1_valid = v1; r1_we = we; r1_addr = a1[AW-1:0]; r1_wdata = wd; r1_lock = l1;
    #1;
    check_eq("r0_ready", r0_ready, (g == 0));
    check_eq("r1_ready", r1_ready, (g == 1));
    if (g < 0) begin
      check_eq("idle_mem_we", mem_we, 0);
      check_eq("idle_mem_addr", mem_addr, 0);
    end else begin
      a      = (g == 0) ? a0 : a1;
      in_rng = (a < DEPTH);
      check_eq("mem_addr", mem_addr, in_rng ? a : 0);
      check_eq("mem_we", mem_we, (g == 1) && we && in_rng);
      if (g == 1 && we && in_rng) check_eq("mem_wd", mem_wd, wd);
      e.owner = (g == 1);
      e.err   = !in_rng;
      e.due   = cyc + 1;
      if (!in_rng || (g == 1 && we)) e.rdata = '0;
      else                            e.rdata = shadow[a];
      if (g == 1 && we && in_rng) shadow[a] = wd;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, '0, 0, -1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]    = 32'h5A000000 ^ (i * 7);
      shadow[i] = 32'h5A000000 ^ (i * 7);
    end
    mem_q = '0;
    rst_n = 1'b0;
    r0_valid = 0; r0_addr = '0; r0_lock = 0;
    r1_valid = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0; r1_lock = 0;

    // Held in reset with both valids high: nothing may be ready.
    repeat (3) drive(1, 5, 0, 1, 0, 6, '0, 0, -1);
    idle(1);
    rst_n = 1'b1;

    // Contention right after reset: requester 0 first.
    drive(1, 5, 0, 1, 0, 6, '0, 0, 0);
    // Write then read back through the other requester.
    drive(0, 0, 0, 1, 1, 100, 32'hDEADBEEF, 0, 1);
    drive(1, 100, 0, 0, 0, 0, '0, 0, 0);
    // Range boundary.
    drive(1, 70000, 0, 0, 0, 0, '0, 0, 0);
    drive(1, 69999, 0, 0, 0, 0, '0, 0, 0);
    drive(0, 0, 0, 1, 1, 70000, 32'h12345678, 0, 1);
    drive(0, 0, 0, 1, 0, 131071, '0, 0, 1);
    drive(0, 0, 0, 1, 1, 69999, 32'hCAFEF00D, 0, 1);
    drive(1, 69999, 0, 0, 0, 0, '0, 0, 0);
    idle(1);

    // Locked burst of 20 from requester 1, cut at MAX_BURST.
    drive(0, 0, 0, 1, 0, 200, '0, 1, 1);
    for (int i = 1; i < MAX_BURST; i++) drive(1, 7, 0, 1, 0, 200 + i, '0, 1, 1);
    drive(1, 7, 0, 1, 0, 200 + MAX_BURST, '0, 1, 0);
    for (int i = MAX_BURST; i < 20; i++) drive(0, 0, 0, 1, 0, 200 + i, '0, (i != 19), 1);
    idle(1);

    // Owner dropping valid releases the lock; the other side waits one cycle.
    drive(1, 40, 1, 0, 0, 0, '0, 0, 0);
    drive(0, 0, 0, 1, 0, 41, '0, 0, -1);
    drive(0, 0, 0, 1, 0, 41, '0, 0, 1);
    idle(1);

    // Reset right after a locked r0 accept: response dropped, lock gone.
    drive(1, 9, 1, 0, 0, 0, '0, 0, 0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rst_r0_ready", r0_ready, 0);
    check_eq("rst_r1_ready", r1_ready, 0);
    idle(1);
    rst_n = 1'b1;

    // Both continuously valid after reset.
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
      drive(1, 20 + i, 0, 1, 0, 30 + i, '0, 0, i % 2);
`else
      drive(1, 20 + i, 0, 1, 0, 30 + i, '0, 0, 0);
`endif
    end
    drive(0, 0, 0, 1, 0, 11, '0, 0, 1);
    idle(3);

    check_eq("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
